regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Debug-side reader that walks the CPU register file and streams every register out as (index, data) beats on a valid/ready interface.
- Used by the testbench/debug path to snapshot architectural state without stopping writeback.
- Uses a dedicated asynchronous (combinational) read port on the register file: drives the address, samples the data.
- Complements the regfile's write path: the regfile is written by the core and read out here.

Parameters:
- ADDRESS_WIDTH, 5, register index width; register count = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- SKIP_ZERO, 1, when 1 the walk starts at index 1 (x0 not emitted); when 0 it starts at index 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  cancel an in-progress dump.
- rd_addr  output  ADDRESS_WIDTH  address to the regfile debug read port.
- rd_data  input  DATA_WIDTH  combinational read data for rd_addr.
- dump_valid  output  1  beat valid.
- dump_ready  input  1  sink accepts the beat.
- dump_idx  output  ADDRESS_WIDTH  register index of the current beat.
- dump_data  output  DATA_WIDTH  register value of the current beat.
- dump_last  output  1  high with the beat for the highest index.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0: dump_valid, dump_last, busy, done, dump_idx, dump_data, rd_addr.
  - Reset mid-dump abandons the walk; no done pulse.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE:
  - rd_addr holds its last value.
  - On start: idx <= (SKIP_ZERO ? 1 : 0); go to READ.
- READ (one cycle):
  - rd_addr = idx.
  - At the clock edge: dump_data <= rd_data, dump_idx <= idx, dump_valid <= 1, dump_last <= (idx == 2**ADDRESS_WIDTH-1); go to SEND.
- SEND:
  - dump_valid stays 1; dump_idx, dump_data and dump_last are held stable until the handshake completes.
  - Handshake = dump_valid & dump_ready at a rising edge.
  - On handshake with last=0: dump_valid <= 0, idx <= idx+1, go to READ.
  - On handshake with last=1: dump_valid <= 0, dump_last <= 0, go to FIN.
- FIN: done=1 for exactly this cycle; return to IDLE.
- Throughput: at most one beat per 2 cycles (READ then SEND).
- Latency: start to first dump_valid = 2 edges.
- Full dump with dump_ready tied high:
  - SKIP_ZERO=1: 31 beats, 62 cycles, then the done pulse.
  - SKIP_ZERO=0: 32 beats, 64 cycles, then the done pulse.
- Data is sampled in READ only. A regfile write to that index in a later cycle is not reflected; a write in the same cycle follows the regfile's read-during-write behaviour (old value).
- start while busy is ignored; no queuing.
- abort in READ or SEND (synchronous):
  - Next state IDLE; dump_valid and dump_last cleared; no done pulse.
  - abort takes priority over a same-cycle handshake; that beat counts as not delivered.
  - abort in IDLE or FIN has no effect (the FIN done pulse still occurs).
- idx is ADDRESS_WIDTH+1 bits internally, so the increment past the top index cannot wrap to 0. The last flag, not the counter, terminates the walk.
- busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared CPU package holds:
  - the state enum type (IDLE, READ, SEND, FIN);
  - the constant REG_COUNT = 2**ADDRESS_WIDTH;
  - a dump_beat_t struct {idx, data, last}.
- No sub-module is needed. The output holding register is a single always_ff block inside this module.
- The regfile gains a third asynchronous read port (addr/data) wired to rd_addr/rd_data. That change belongs to the regfile, not to this block.

Test Plan:
- Regs preloaded with x[i]=0x1000+i, SKIP_ZERO=1, ready=1, pulse start -> 31 beats, idx 1..31, data 0x1001..0x101F; dump_last only on idx 31; done one cycle after the last handshake; busy low afterwards.
- Same preload, ready toggling 1-of-3 cycles -> beats identical; idx/data/last held stable while valid & !ready; no beat lost or duplicated.
- SKIP_ZERO=0 -> 32 beats, first beat idx 0 data 0x0.
- start pulsed again during a dump at beat idx 5 -> ignored; sequence continues to idx 31; exactly one done pulse.
- abort asserted in SEND at idx 10 together with ready=1 -> next cycle IDLE, valid 0, no done; a fresh start then restarts at idx 1.
- rst asserted asynchronously mid-cycle during beat idx 20 -> all outputs 0 immediately without a clock edge; no done pulse; a later start produces a full correct dump.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared types for the register-file dump reader: walk states, register count
// and the (index, data, last) beat record held on the output side.
package regfile_dump_reader_pkg;

  localparam int DUMP_ADDRESS_WIDTH = 5;
  localparam int DUMP_DATA_WIDTH    = 32;
  localparam int REG_COUNT          = 2 ** DUMP_ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } dump_state_t;

  typedef struct packed {
    logic [DUMP_ADDRESS_WIDTH-1:0] idx;
    logic [DUMP_DATA_WIDTH-1:0]    data;
    logic                          last;
  } dump_beat_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file through its asynchronous debug read port and streams
// each register out as one (index, data, last) beat on a valid/ready interface.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DUMP_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DUMP_DATA_WIDTH,
  parameter int SKIP_ZERO     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDRESS_WIDTH-1:0] dump_idx,
  output logic [DATA_WIDTH-1:0]    dump_data,
  output logic                     dump_last,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  // Handshake: a beat transfers on a rising edge where dump_valid and
  // dump_ready are both high. Once raised, dump_valid and the beat fields stay
  // put until that transfer happens (or an abort/reset drops the beat).

  // The counter is one bit wider than the index so that stepping past the top
  // register can never alias back to register 0; the last flag ends the walk.
  localparam logic [ADDRESS_WIDTH:0] LAST_IDX  = (ADDRESS_WIDTH+1)'(2 ** ADDRESS_WIDTH - 1);
  localparam logic [ADDRESS_WIDTH:0] FIRST_IDX = (ADDRESS_WIDTH+1)'((SKIP_ZERO != 0) ? 1 : 0);

  dump_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH:0]  idx_q;
  dump_beat_t              beat_q;
  logic                    valid_q;
  logic                    handshake;

  assign handshake = valid_q & dump_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_READ;
      end
      ST_READ: begin
        state_d = abort ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        // Abort wins over a same-cycle handshake: that beat is not delivered.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (handshake) begin
          state_d = beat_q.last ? ST_FIN : ST_READ;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Walk counter and output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) idx_q <= FIRST_IDX;
        end
        ST_READ: begin
          if (abort) begin
            valid_q     <= 1'b0;
            beat_q.last <= 1'b0;
          end else begin
            // The register value is captured here only; later writes are not seen.
            beat_q.idx  <= idx_q[ADDRESS_WIDTH-1:0];
            beat_q.data <= rd_data;
            beat_q.last <= (idx_q == LAST_IDX);
            valid_q     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (abort) begin
            valid_q     <= 1'b0;
            beat_q.last <= 1'b0;
          end else if (handshake) begin
            valid_q <= 1'b0;
            if (beat_q.last) begin
              beat_q.last <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The read address follows the counter, so it holds its last value in IDLE.
  assign rd_addr    = idx_q[ADDRESS_WIDTH-1:0];
  assign dump_valid = valid_q;
  assign dump_idx   = beat_q.idx;
  assign dump_data  = beat_q.data;
  assign dump_last  = beat_q.last;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign state_dbg  = state_q;

endmodule
